uart_burst_tx: RTL and testbench
================================

UART_BURST_TX -- requirements
Module: uart_burst_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit; legal range 2..65535.
REQ-002 Parameter BURST_LEN, default 16, characters per burst; legal range 1..255.
REQ-003 Parameter FIRST_CHAR, default 8'h30 ("0"), first character of the incrementing sequence.
REQ-004 Parameter LAST_CHAR, default 8'h7A ("z"), last character before wrap; SHALL be >= FIRST_CHAR.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  one-cycle burst request, already debounced.
REQ-008 i_mode  input  1  0 = incrementing sequence, 1 = repeat i_char.
REQ-009 i_char  input  8  character for mode 1.
REQ-010 i_abort  input  1  level; requests early burst end.
REQ-011 o_tx  output  1  UART line, 8N1, LSB first, idle high.
REQ-012 o_busy  output  1  high from start acceptance until return to IDLE.
REQ-013 o_done  output  1  one-cycle pulse at burst end.
REQ-014 o_char_cnt  output  8  characters completed in the current or last burst.

Function
REQ-015 FSM states SHALL be IDLE, START_BIT, DATA, STOP, NEXT.
REQ-016 IDLE: i_start=1 and i_abort=0 -> START_BIT next cycle; o_tx low and o_busy high on that same edge (1-cycle latency).
REQ-017 On acceptance: o_char_cnt cleared to 0; mode and i_char latched; i_mode/i_char changes mid-burst have no effect.
REQ-018 i_start outside IDLE SHALL be ignored (no queuing).
REQ-019 START_BIT, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-020 DATA sends bits 0..7 of the current character, LSB first; STOP drives o_tx high.
REQ-021 NEXT (one cycle, o_tx high): o_char_cnt increments; current character advances; if o_char_cnt reaches BURST_LEN or abort is pending -> IDLE with o_done pulsed, else -> START_BIT.
REQ-022 Inter-character gap SHALL be exactly 1 cycle (NEXT) of idle-high line.
REQ-023 Mode 0 advance: char+1, except LAST_CHAR -> FIRST_CHAR (wrap).
REQ-024 Mode 0 character register SHALL persist across bursts; the next burst resumes at the following character.
REQ-025 Mode 1: every character equals the latched i_char; the mode 0 register is not advanced.
REQ-026 i_abort sampled high while busy sets an abort-pending flag; the current frame completes fully, then NEXT -> IDLE; frames are never truncated.
REQ-027 i_start and i_abort both high in IDLE: abort wins, no burst.
REQ-028 o_busy SHALL fall on the same edge o_done rises.

Reset
REQ-029 rst low, at any time including mid-frame: state IDLE, o_tx=1, o_busy=0, o_done=0, o_char_cnt=0, character register=FIRST_CHAR, abort-pending=0, bit and cycle counters=0.
REQ-030 The first i_start after rst release SHALL be accepted normally.

Configuration
REQ-031 Macro CRLF_EN: when defined, after BURST_LEN characters the block SHALL send 8'h0D then 8'h0A as full frames before o_done; CR/LF do not increment o_char_cnt and do not advance the character register.
REQ-032 With CRLF_EN defined, an abort ends the burst without sending CR/LF.
REQ-033 Without CRLF_EN, no trailer is sent and behaviour is per REQ-021.

Verification (CLKS_PER_BIT=4, BURST_LEN=3, CRLF_EN undefined unless stated)
REQ-034 Reset then i_start, mode 0 -> frames "0","1","2" (0x30,0x31,0x32), each 40 cycles plus 1 gap; o_done pulse; o_char_cnt=3; second burst sends "3","4","5".
REQ-035 Preload FIRST_CHAR=8'h79, LAST_CHAR=8'h7A -> burst sends 0x79,0x7A,0x79 (wrap).
REQ-036 Mode 1, i_char=0x41, toggle i_char to 0x42 mid-burst -> three 0x41 frames.
REQ-037 i_abort pulse during bit 3 of first frame -> that frame completes, o_done pulses, o_char_cnt=1; i_start while busy ignored.
REQ-038 rst low mid-DATA -> o_tx=1, o_busy=0 immediately; next burst starts at 0x30.
REQ-039 CRLF_EN defined -> frames 0x30,0x31,0x32,0x0D,0x0A, then o_done, o_char_cnt=3.

Source files
------------

// File: rtl/uart_burst_tx.sv
// uart_burst_tx -- sends a burst of 8N1 UART characters, LSB first.
//   Mode 0 sends an incrementing character sequence FIRST_CHAR..LAST_CHAR
//   that wraps around and carries on from burst to burst. Mode 1 repeats
//   the character latched at start. An abort lets the current frame finish
//   and then ends the burst.
//   Optional macro CRLF_EN: a full burst is followed by CR, LF frames.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_start         one-cycle burst request (ignored while busy)
//   i_mode, i_char  0 = sequence, 1 = repeat i_char (latched at start)
//   i_abort         level; ends the burst after the current frame
//   o_tx            UART line, idle high
//   o_busy          high while a burst is in progress
//   o_done          one-cycle pulse when the burst ends
//   o_char_cnt      characters completed in the current or last burst
module uart_burst_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         BURST_LEN    = 16,
  parameter logic [7:0] FIRST_CHAR   = 8'h30,
  parameter logic [7:0] LAST_CHAR    = 8'h7A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic [7:0] i_char,
  input  logic       i_abort,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_char_cnt
);
  typedef enum logic [2:0] {IDLE, START_BIT, DATA, STOP, NEXT} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  BURST_CNT = 8'(BURST_LEN);

  state_t      state, state_d;
  logic [15:0] clk_cnt, clk_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  seq_char, seq_char_d;
  logic [7:0]  char_lat, char_lat_d;
  logic [7:0]  char_cnt_d, cnt_inc, frame_char;
  logic        mode_lat, mode_lat_d;
  logic        abort_pend, abort_pend_d, abort_now;
  logic        tx_d, busy_d, done_d, bit_last;
  logic [1:0]  trl, trl_d;  // 0 = payload, 1 = CR frame, 2 = LF frame

  // Character carried by the current frame; stable for the whole frame
  // because its sources only change in NEXT or at acceptance.
  always_comb begin
    if (trl == 2'd1)      frame_char = 8'h0D;
    else if (trl == 2'd2) frame_char = 8'h0A;
    else if (mode_lat)    frame_char = char_lat;
    else                  frame_char = seq_char;
  end

  always_comb begin
    state_d      = state;
    clk_cnt_d    = clk_cnt;
    bit_idx_d    = bit_idx;
    seq_char_d   = seq_char;
    char_lat_d   = char_lat;
    mode_lat_d   = mode_lat;
    char_cnt_d   = o_char_cnt;
    abort_pend_d = abort_pend;
    trl_d        = trl;
    done_d       = 1'b0;
    bit_last     = (clk_cnt == BIT_LAST);
    abort_now    = abort_pend | i_abort;
    cnt_inc      = o_char_cnt + 8'd1;

    if (state != IDLE && i_abort) abort_pend_d = 1'b1;

    case (state)
      IDLE: begin
        // abort in the same cycle as start suppresses the burst
        if (i_start && !i_abort) begin
          state_d      = START_BIT;
          clk_cnt_d    = 16'd0;
          char_cnt_d   = 8'd0;
          mode_lat_d   = i_mode;
          char_lat_d   = i_char;
          abort_pend_d = 1'b0;
          trl_d        = 2'd0;
        end
      end
      START_BIT: begin
        clk_cnt_d = clk_cnt + 16'd1;
        if (bit_last) begin
          clk_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        clk_cnt_d = clk_cnt + 16'd1;
        if (bit_last) begin
          clk_cnt_d = 16'd0;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        clk_cnt_d = clk_cnt + 16'd1;
        if (bit_last) begin
          clk_cnt_d = 16'd0;
          state_d   = NEXT;
        end
      end
      NEXT: begin
        state_d = START_BIT;
        if (trl == 2'd0) begin
          char_cnt_d = cnt_inc;
          // mode 1 leaves the sequence untouched so mode 0 resumes cleanly
          if (!mode_lat)
            seq_char_d = (seq_char == LAST_CHAR) ? FIRST_CHAR : seq_char + 8'd1;
        end
`ifdef CRLF_EN
        if (abort_now) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (trl == 2'd0) begin
          if (cnt_inc == BURST_CNT) trl_d = 2'd1;
        end else if (trl == 2'd1) begin
          trl_d = 2'd2;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        if (abort_now || cnt_inc == BURST_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
        if (state_d == IDLE) begin
          abort_pend_d = 1'b0;
          trl_d        = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // line level registered from the next state so o_tx is glitch-free
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = frame_char[bit_idx_d];
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clk_cnt    <= 16'd0;
      bit_idx    <= 3'd0;
      seq_char   <= FIRST_CHAR;
      char_lat   <= 8'd0;
      mode_lat   <= 1'b0;
      o_char_cnt <= 8'd0;
      abort_pend <= 1'b0;
      trl        <= 2'd0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_d;
      clk_cnt    <= clk_cnt_d;
      bit_idx    <= bit_idx_d;
      seq_char   <= seq_char_d;
      char_lat   <= char_lat_d;
      mode_lat   <= mode_lat_d;
      o_char_cnt <= char_cnt_d;
      abort_pend <= abort_pend_d;
      trl        <= trl_d;
      o_tx       <= tx_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_burst_tx.sv
// Directed bench for uart_burst_tx with CLKS_PER_BIT=4, BURST_LEN=3.
// A second instance with FIRST_CHAR=8'h79 covers the sequence wrap.
// Timing reference: the negedge where the start bit is first seen is
// cycle 0; data bit i spans cycles 4+4i..7+4i, stop 36..39, gap 40,
// and o_done shows at cycle 41 after the last frame.
module tb_uart_burst_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0, w_start = 1'b0;
  logic       i_mode = 1'b0, i_abort = 1'b0;
  logic [7:0] i_char = 8'h00;
  logic       o_tx, o_busy, o_done, w_tx, w_busy, w_done;
  logic [7:0] o_char_cnt, w_cnt;
  int         tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_burst_tx #(.CLKS_PER_BIT(4), .BURST_LEN(3)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_char(i_char),
    .i_abort(i_abort), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done),
    .o_char_cnt(o_char_cnt));

  uart_burst_tx #(.CLKS_PER_BIT(4), .BURST_LEN(3), .FIRST_CHAR(8'h79),
                  .LAST_CHAR(8'h7A)) u_wrap (
    .clk(clk), .rst(rst), .i_start(w_start), .i_mode(i_mode), .i_char(i_char),
    .i_abort(i_abort), .o_tx(w_tx), .o_busy(w_busy), .o_done(w_done),
    .o_char_cnt(w_cnt));

  function automatic logic line(input bit sel);
    return sel ? w_tx : o_tx;
  endfunction

  task automatic start_burst(input bit sel);
    @(negedge clk);
    if (sel) w_start = 1'b1; else i_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    i_start = 1'b0;
  endtask

  // Captures one frame; err flags a missing start bit or bad stop bit.
  // Returns at cycle 38 of the frame.
  task automatic rx_frame(input bit sel, output logic [7:0] c, output int st,
                          output bit err);
    err = 1'b0;
    c   = 8'h00;
    st  = cyc;
    for (int k = 0; k < 200 && line(sel) !== 1'b0; k++) @(negedge clk);
    if (line(sel) !== 1'b0) begin
      err = 1'b1;
      return;
    end
    st = cyc;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) c[3'((k - 6) / 4)] = line(sel);
      if (k == 2 && line(sel) !== 1'b0) err = 1'b1;
      if (k == 38 && line(sel) !== 1'b1) err = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_char_cnt !== 8'd0 ||
        w_tx !== 1'b1)
      begin fails++; $display("FAIL reset: tx=%b busy=%b done=%b cnt=%0d wtx=%b, want 1 0 0 0 1",
                              o_tx, o_busy, o_done, o_char_cnt, w_tx); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_seq(input logic [7:0] base, input string nm);
    logic [7:0] exp[$];
    logic [7:0] c;
    int st, prev;
    bit err;
    exp = {base, base + 8'd1, base + 8'd2};
`ifdef CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
    i_mode = 1'b0;
    start_burst(0);
    tests++;
    if (o_tx !== 1'b0 || o_busy !== 1'b1)
      begin fails++; $display("FAIL %s_latency: tx=%b busy=%b, want 0 1", nm, o_tx, o_busy); end
    prev = -1;
    foreach (exp[i]) begin
      rx_frame(0, c, st, err);
      tests++;
      if (err || c !== exp[i])
        begin fails++; $display("FAIL %s_char%0d: got %h err=%b, want %h", nm, i, c, err, exp[i]); end
      if (prev >= 0) begin
        tests++;
        if (st - prev !== 41)
          begin fails++; $display("FAIL %s_gap%0d: period %0d, want 41", nm, i, st - prev); end
      end
      prev = st;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b1)
      begin fails++; $display("FAIL %s_gapcyc: done=%b busy=%b, want 0 1", nm, o_done, o_busy); end
    @(negedge clk);
    tests++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_char_cnt !== 8'd3)
      begin fails++; $display("FAIL %s_done: done=%b busy=%b cnt=%0d, want 1 0 3",
                              nm, o_done, o_busy, o_char_cnt); end
    @(negedge clk);
    tests++;
    if (o_done !== 1'b0)
      begin fails++; $display("FAIL %s_done_pulse: done=%b, want 0", nm, o_done); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp[$];
    logic [7:0] c;
    int st;
    bit err;
    exp = {8'h79, 8'h7A, 8'h79};
`ifdef CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
    i_mode = 1'b0;
    start_burst(1);
    foreach (exp[i]) begin
      rx_frame(1, c, st, err);
      tests++;
      if (err || c !== exp[i])
        begin fails++; $display("FAIL wrap_char%0d: got %h err=%b, want %h", i, c, err, exp[i]); end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (w_done !== 1'b1 || w_busy !== 1'b0 || w_cnt !== 8'd3)
      begin fails++; $display("FAIL wrap_done: done=%b busy=%b cnt=%0d, want 1 0 3",
                              w_done, w_busy, w_cnt); end
  endtask

  task automatic test_mode1;
    logic [7:0] exp[$];
    logic [7:0] c;
    int st;
    bit err;
    exp = {8'h41, 8'h41, 8'h41};
`ifdef CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
    i_mode = 1'b1;
    i_char = 8'h41;
    start_burst(0);
    i_char = 8'h42;   // mid-burst changes must not matter
    i_mode = 1'b0;
    foreach (exp[i]) begin
      rx_frame(0, c, st, err);
      tests++;
      if (err || c !== exp[i])
        begin fails++; $display("FAIL mode1_char%0d: got %h err=%b, want %h", i, c, err, exp[i]); end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (o_done !== 1'b1 || o_char_cnt !== 8'd3)
      begin fails++; $display("FAIL mode1_done: done=%b cnt=%0d, want 1 3", o_done, o_char_cnt); end
  endtask

  task automatic test_abort;
    logic [7:0] c;
    int st;
    bit err, quiet;
    i_mode = 1'b0;
    start_burst(0);
    fork
      rx_frame(0, c, st, err);
      begin
        repeat (17) @(negedge clk);   // inside data bit 3
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        repeat (3) @(negedge clk);
        i_start = 1'b1;               // while busy: ignored
        @(negedge clk);
        i_start = 1'b0;
      end
    join
    tests++;
    if (err || c !== 8'h39)
      begin fails++; $display("FAIL abort_frame: got %h err=%b, want 39", c, err); end
    repeat (2) @(negedge clk);
    tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b1)
      begin fails++; $display("FAIL abort_gap: done=%b busy=%b, want 0 1", o_done, o_busy); end
    @(negedge clk);
    tests++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_char_cnt !== 8'd1)
      begin fails++; $display("FAIL abort_done: done=%b busy=%b cnt=%0d, want 1 0 1",
                              o_done, o_busy, o_char_cnt); end
    quiet = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (quiet !== 1'b1)
      begin fails++; $display("FAIL abort_idle_after: line activity %b, want quiet", ~quiet); end
  endtask

  task automatic test_abort_idle;
    bit quiet;
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (o_tx !== 1'b1 || o_busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (quiet !== 1'b1)
      begin fails++; $display("FAIL start_abort_idle: busy=%b tx=%b, want 0 1", o_busy, o_tx); end
  endtask

  task automatic test_reset_mid;
    i_mode = 1'b0;
    start_burst(0);
    repeat (13) @(negedge clk);  // data bit 2 of 0x3A, a low bit
    tests++;
    if (o_tx !== 1'b0 || o_busy !== 1'b1)
      begin fails++; $display("FAIL rstmid_pre: tx=%b busy=%b, want 0 1", o_tx, o_busy); end
    rst = 1'b0;
    #1;
    tests++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_char_cnt !== 8'd0)
      begin fails++; $display("FAIL rstmid: tx=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                              o_tx, o_busy, o_done, o_char_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_seq(8'h30, "seq1");
    test_seq(8'h33, "seq2");
    test_mode1();
    test_seq(8'h36, "seq3");
    test_abort();
    test_abort_idle();
    test_reset_mid();
    test_seq(8'h30, "after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
